// File: rtl/inst_package.sv
// Shared sub-core definitions used by the main core and the dispatcher.
//   SUBCORE_NUM    : number of sub-cores in the array
//   PC_W           : program-counter width
//   dispatch_req_t : a dispatch request as produced by the main core
package inst_package;

    localparam int SUBCORE_NUM = 8;
    localparam int PC_W        = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
    } dispatch_req_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Small synchronous FIFO holding pending dispatch PCs.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of entries held
module dispatch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/subcore_dispatcher.sv
// Dispatches queued PCs from the main core onto idle sub-cores in
// round-robin order, tracks per-core busy state and completions, and
// offers a barrier handshake that waits for all work to drain.
// Ports:
//   clk, rstn                  : clock, asynchronous active-high reset
//   req_valid, req_pc, req_ready : dispatch request handshake
//   exec_requested             : one-hot, one-cycle start pulse per core
//   requested_pc               : per-core PC, core i at [i*PC_W +: PC_W]
//   subcore_ended              : per-core completion pulse
//   busy                       : per-core dispatched-and-not-ended flag
//   all_idle                   : no busy core and empty queue
//   done_count                 : wrapping count of accepted completions
//   sync_req, sync_ack         : barrier request / barrier reached
module subcore_dispatcher #(
    parameter int SUBCORE_NUM = inst_package::SUBCORE_NUM,
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_W        = inst_package::PC_W,
    parameter int COUNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    input  logic [PC_W-1:0]             req_pc,
    output logic                        req_ready,
    output logic [SUBCORE_NUM-1:0]      exec_requested,
    output logic [SUBCORE_NUM*PC_W-1:0] requested_pc,
    input  logic [SUBCORE_NUM-1:0]      subcore_ended,
    output logic [SUBCORE_NUM-1:0]      busy,
    output logic                        all_idle,
    output logic [COUNT_W-1:0]          done_count,
    input  logic                        sync_req,
    output logic                        sync_ack
);

    localparam int IDX_W  = (SUBCORE_NUM > 1) ? $clog2(SUBCORE_NUM) : 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

    // First idle core at or after start, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [SUBCORE_NUM-1:0] idle,
                                                 input logic [IDX_W-1:0]       start);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < SUBCORE_NUM; k++) begin
            idx = (int'(start) + k) % SUBCORE_NUM;
            if (!found && idle[IDX_W'(idx)]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [COUNT_W-1:0] popcount(input logic [SUBCORE_NUM-1:0] v);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < SUBCORE_NUM; k++) begin
            cnt = cnt + COUNT_W'(v[k]);
        end
        return cnt;
    endfunction

    logic [IDX_W-1:0]       rr_ptr;
    logic [PC_W-1:0]        q_head;
    logic                   q_full;
    logic                   q_empty;
    logic [QCNT_W-1:0]      q_count;
    logic                   push;
    logic                   dispatch;
    logic [IDX_W-1:0]       target;
    logic [SUBCORE_NUM-1:0] dispatch_vec;
    logic [SUBCORE_NUM-1:0] ended_valid;

    // A full queue refuses pushes even when it pops in the same cycle.
    assign req_ready   = !q_full && !sync_req;
    assign push        = req_valid && req_ready;
    assign dispatch    = !q_empty && (busy != '1);
    assign target      = rr_pick(~busy, rr_ptr);
    // End pulses from cores that were never dispatched (or were forgotten by reset) are dropped.
    assign ended_valid = subcore_ended & busy;
    assign all_idle    = (busy == '0) && (q_count == '0);

    always_comb begin
        dispatch_vec = '0;
        if (dispatch) dispatch_vec[target] = 1'b1;
    end

    dispatch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (PC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rstn),
        .push      (push),
        .push_data (req_pc),
        .pop       (dispatch),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rr_ptr         <= '0;
            busy           <= '0;
            exec_requested <= '0;
            requested_pc   <= '0;
            done_count     <= '0;
            sync_ack       <= 1'b0;
        end else begin
            exec_requested <= dispatch_vec;
            // A dispatch only targets an idle core, so set and clear never collide.
            busy           <= (busy & ~ended_valid) | dispatch_vec;
            done_count     <= done_count + popcount(ended_valid);
            sync_ack       <= sync_req && q_empty && (busy == '0) && !dispatch;
            if (dispatch) begin
                rr_ptr <= (target == IDX_W'(SUBCORE_NUM - 1)) ? '0 : target + 1'b1;
            end
            for (int i = 0; i < SUBCORE_NUM; i++) begin
                if (dispatch_vec[i]) requested_pc[i*PC_W +: PC_W] <= q_head;
            end
        end
    end

endmodule

// File: tb/tb_subcore_dispatcher.sv
// Directed bench for subcore_dispatcher with default parameters
// (8 sub-cores, 4-entry queue, 32-bit PC, 16-bit completion count).
module tb_subcore_dispatcher;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic [31:0]  req_pc;
    logic         req_ready;
    logic [7:0]   exec_requested;
    logic [255:0] requested_pc;
    logic [7:0]   subcore_ended;
    logic [7:0]   busy;
    logic         all_idle;
    logic [15:0]  done_count;
    logic         sync_req;
    logic         sync_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subcore_dispatcher dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .exec_requested (exec_requested),
        .requested_pc   (requested_pc),
        .subcore_ended  (subcore_ended),
        .busy           (busy),
        .all_idle       (all_idle),
        .done_count     (done_count),
        .sync_req       (sync_req),
        .sync_ack       (sync_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pc_of(input int i);
        return 64'(requested_pc[i*32 +: 32]);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1; req_valid = 1'b0; req_pc = '0; subcore_ended = '0; sync_req = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_exec",     64'(exec_requested), 64'h0);
        check("rst_busy",     64'(busy),           64'h0);
        check("rst_all_idle", 64'(all_idle),       64'h1);
        check("rst_done",     64'(done_count),     64'h0);
        check("rst_ready",    64'(req_ready),      64'h1);
        check("rst_ack",      64'(sync_ack),       64'h0);
        check("rst_pcs",      64'(|requested_pc),  64'h0);
        rstn = 1'b0;
        step();

        // Single dispatch
        req_valid = 1'b1; req_pc = 32'h100;
        step();
        req_valid = 1'b0;
        check("single_wait_exec", 64'(exec_requested), 64'h0);
        check("single_queued",    64'(all_idle),       64'h0);
        step();
        check("single_exec",  64'(exec_requested), 64'h01);
        check("single_pc0",   pc_of(0),            64'h100);
        check("single_busy",  64'(busy),           64'h01);
        step();
        check("single_pulse_len", 64'(exec_requested), 64'h0);
        check("single_busy_hold", 64'(busy),           64'h01);
        subcore_ended = 8'h01;
        step();
        subcore_ended = 8'h00;
        check("single_end_busy", 64'(busy),       64'h0);
        check("single_end_done", 64'(done_count), 64'h1);
        check("single_end_idle", 64'(all_idle),   64'h1);

        // Reset in the middle of dispatching (rr_ptr=1, one entry queued)
        req_valid = 1'b1; req_pc = 32'h200;
        step();
        req_pc = 32'h300;
        step();
        req_valid = 1'b0;
        check("mid_exec", 64'(exec_requested), 64'h02);
        rstn = 1'b1;
        step();
        check("mid_rst_exec",  64'(exec_requested), 64'h0);
        check("mid_rst_busy",  64'(busy),           64'h0);
        check("mid_rst_pc1",   pc_of(1),            64'h0);
        check("mid_rst_done",  64'(done_count),     64'h0);
        check("mid_rst_idle",  64'(all_idle),       64'h1);
        check("mid_rst_ready", 64'(req_ready),      64'h1);
        rstn = 1'b0; subcore_ended = 8'hFF;
        step();
        subcore_ended = 8'h00;
        check("mid_stale_done", 64'(done_count),     64'h0);
        check("mid_stale_busy", 64'(busy),           64'h0);
        check("mid_queue_gone", 64'(exec_requested), 64'h0);

        // Saturation: 12 back-to-back requests, pulses to cores 0..7
        for (int c = 0; c <= 12; c++) begin
            if (c >= 2 && c <= 9) begin
                check("sat_exec", 64'(exec_requested), 64'(1 << (c - 2)));
                check("sat_pc",   pc_of(c - 2),        64'(c - 2));
            end else begin
                check("sat_exec_quiet", 64'(exec_requested), 64'h0);
            end
            if (c < 12) begin
                check("sat_ready", 64'(req_ready), 64'h1);
                req_valid = 1'b1; req_pc = 32'(c);
            end else begin
                req_valid = 1'b0;
            end
            step();
        end
        check("sat_full_ready", 64'(req_ready), 64'h0);
        check("sat_full_busy",  64'(busy),      64'hFF);
        check("sat_not_idle",   64'(all_idle),  64'h0);
        subcore_ended = 8'h08;
        step();
        subcore_ended = 8'h00;
        check("sat_end3_busy", 64'(busy),           64'hF7);
        check("sat_end3_done", 64'(done_count),     64'h1);
        check("sat_end3_exec", 64'(exec_requested), 64'h0);
        check("sat_end3_rdy",  64'(req_ready),      64'h0);
        step();
        check("sat_redisp_exec", 64'(exec_requested), 64'h08);
        check("sat_redisp_pc3",  pc_of(3),            64'h8);
        check("sat_redisp_rdy",  64'(req_ready),      64'h1);
        check("sat_redisp_busy", 64'(busy),           64'hFF);

        // Simultaneous ends on cores 1, 2, 5; queue still holds 9, 10, 11
        subcore_ended = 8'b0010_0110;
        step();
        subcore_ended = 8'h00;
        check("sim_done", 64'(done_count), 64'h4);
        check("sim_busy", 64'(busy),       64'hD9);
        step();
        check("sim_exec5", 64'(exec_requested), 64'h20);
        check("sim_pc5",   pc_of(5),            64'h9);
        step();
        check("sim_exec1", 64'(exec_requested), 64'h02);
        check("sim_pc1",   pc_of(1),            64'hA);
        step();
        check("sim_exec2", 64'(exec_requested), 64'h04);
        check("sim_pc2",   pc_of(2),            64'hB);
        check("sim_busy2", 64'(busy),           64'hFF);

        // End pulse on an idle core is not counted
        subcore_ended = 8'hFF;
        step();
        subcore_ended = 8'h80;
        check("all_end_done", 64'(done_count), 64'd12);
        check("all_end_idle", 64'(all_idle),   64'h1);
        step();
        subcore_ended = 8'h00;
        check("idle_end_done", 64'(done_count), 64'd12);

        // Round-robin: bring rr_ptr to 5 with all cores idle
        req_valid = 1'b1; req_pc = 32'hC0;
        step();
        req_pc = 32'hC1;
        step();
        req_valid = 1'b0;
        check("rr_setup3", 64'(exec_requested), 64'h08);
        step();
        check("rr_setup4", 64'(exec_requested), 64'h10);
        subcore_ended = 8'h18;
        step();
        subcore_ended = 8'h00;
        check("rr_all_idle", 64'(busy), 64'h0);
        req_valid = 1'b1; req_pc = 32'hA0;
        step();
        req_pc = 32'hA1;
        step();
        req_valid = 1'b0;
        check("rr_exec5", 64'(exec_requested), 64'h20);
        check("rr_pc5",   pc_of(5),            64'hA0);
        step();
        check("rr_exec6", 64'(exec_requested), 64'h40);
        check("rr_pc6",   pc_of(6),            64'hA1);
        subcore_ended = 8'h60;
        step();
        subcore_ended = 8'h00;
        check("rr_done", 64'(done_count), 64'd16);

        // Barrier: cores 7 and 0 busy, one request queued
        req_valid = 1'b1; req_pc = 32'hB0;
        step();
        req_pc = 32'hB1;
        step();
        check("bar_exec7", 64'(exec_requested), 64'h80);
        req_pc = 32'hB2;
        step();
        check("bar_exec0", 64'(exec_requested), 64'h01);
        req_valid = 1'b0; sync_req = 1'b1;
        #1;
        check("bar_ready_low", 64'(req_ready), 64'h0);
        check("bar_ack_low",   64'(sync_ack),  64'h0);
        step();
        check("bar_exec1",  64'(exec_requested), 64'h02);
        check("bar_pc1",    pc_of(1),            64'hB2);
        check("bar_ack_q",  64'(sync_ack),       64'h0);
        subcore_ended = 8'h81;
        step();
        subcore_ended = 8'h02;
        check("bar_ack_busy", 64'(sync_ack), 64'h0);
        check("bar_busy1",    64'(busy),     64'h02);
        step();
        subcore_ended = 8'h00;
        check("bar_ack_edge", 64'(sync_ack), 64'h0);
        check("bar_drained",  64'(all_idle), 64'h1);
        step();
        check("bar_ack_up", 64'(sync_ack), 64'h1);
        sync_req = 1'b0;
        #1;
        check("bar_ready_back", 64'(req_ready), 64'h1);
        check("bar_ack_hold",   64'(sync_ack),  64'h1);
        step();
        check("bar_ack_down", 64'(sync_ack),   64'h0);
        check("final_done",   64'(done_count), 64'd19);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
